uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 102 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART transmitter
// Define UART_ARB_HEADER_EN to prefix every packet with an 8'h80|id header byte.
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic [N_REQ-1:0][7:0] req_data_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [N_REQ-1:0]      req_last_i,
  output logic [N_REQ-1:0]      req_ready_o,
  output logic [7:0]            data_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic [ID_W-1:0]       grant_id_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, HEADER, STREAM} state_t;

  state_t          state_q;
  logic [ID_W-1:0] grant_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] idx;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;

  // Scan from farthest to nearest so the index closest after ptr_q wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (req_valid_i[idx]) begin
        winner = idx;
      end
    end
  end

  assign sel_valid = req_valid_i[grant_q];
  assign sel_last  = req_last_i[grant_q];
  assign sel_data  = req_data_i[grant_q];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= ID_W'(N_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            grant_q <= winner;
`ifdef UART_ARB_HEADER_EN
            state_q <= HEADER;
`else
            state_q <= STREAM;
`endif
          end
        end
        HEADER: begin
          if (data_ready_i) begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (sel_valid && data_ready_i && sel_last) begin
            ptr_q   <= grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The stream path is a pure mux on the grant; data_valid_o never looks at data_ready_i.
  always_comb begin
    data_o       = 8'h00;
    data_valid_o = 1'b0;
    req_ready_o  = '0;
    case (state_q)
      HEADER: begin
        data_valid_o = 1'b1;
        data_o       = 8'h80 | 8'(grant_q);
      end
      STREAM: begin
        data_valid_o         = sel_valid;
        data_o               = sel_valid ? sel_data : 8'h00;
        req_ready_o[grant_q] = data_ready_i;
      end
      default: ;
    endcase
  end

  assign busy_o     = (state_q != IDLE);
  assign grant_id_o = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
// Honours UART_ARB_HEADER_EN so the same bench covers both builds.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
`ifdef UART_ARB_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              arstn = 1'b0;
  logic [N-1:0][7:0] req_data = '0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_last = '0;
  logic [N-1:0]      req_ready;
  logic [7:0]        data;
  logic              data_valid;
  logic              data_ready = 1'b0;
  logic [IW-1:0]     grant_id;
  logic              busy;

  uart_tx_arbiter #(.N_REQ(N)) dut (
    .clk_i(clk), .arstn_i(arstn),
    .req_data_i(req_data), .req_valid_i(req_valid), .req_last_i(req_last),
    .req_ready_o(req_ready),
    .data_o(data), .data_valid_o(data_valid), .data_ready_i(data_ready),
    .grant_id_o(grant_id), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus state: per-requester byte queues ({last, byte}) and gap controls.
  logic [8:0] pend [N][$];
  bit         gap [N];
  bit         rnd_gap = 1'b0;
  bit         rnd_ready = 1'b0;
  bit         ready_lvl = 1'b1;

  // Reference model: packet-level view of who owns the transmitter.
  bit         m_busy = 1'b0;
  bit         m_hdr = 1'b0;
  int         m_grant = 0;
  int         m_ptr = N - 1;
  logic [7:0] tx_log [$];
  int         grant_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    logic [8:0] f;
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() > 0 && !gap[i] && !(rnd_gap && $urandom_range(3) == 0)) begin
        f = pend[i][0];
        req_valid[i] = 1'b1;
        req_data[i]  = f[7:0];
        req_last[i]  = f[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = 8'($urandom);
        req_last[i]  = 1'($urandom);
      end
    end
    data_ready = rnd_ready ? 1'($urandom_range(1)) : ready_lvl;
  endtask

  task automatic model_step();
    logic [N-1:0] exp_rdy;
    logic [7:0]   hb;
    logic         v;
    if (!m_busy) begin
      chk("idle_busy", busy, 0);
      chk("idle_valid", data_valid, 0);
      chk("idle_data", data, 0);
      chk("idle_ready", req_ready, 0);
      if (|req_valid) begin
        m_grant = rr(m_ptr, req_valid);
        m_busy  = 1'b1;
        m_hdr   = HDR;
      end
    end else begin
      chk("busy", busy, 1);
      chk("grant", grant_id, m_grant);
      if (m_hdr) begin
        hb = 8'h80 | 8'(m_grant);
        chk("hdr_valid", data_valid, 1);
        chk("hdr_data", data, hb);
        chk("hdr_ready", req_ready, 0);
        if (data_ready) m_hdr = 1'b0;
      end else begin
        v = req_valid[m_grant];
        exp_rdy = '0;
        exp_rdy[m_grant] = data_ready;
        chk("stream_valid", data_valid, v);
        chk("stream_data", data, v ? req_data[m_grant] : 8'h00);
        chk("stream_ready", req_ready, exp_rdy);
        if (v && data_ready && req_last[m_grant]) begin
          grant_log.push_back(m_grant);
          m_ptr  = m_grant;
          m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic cycle();
    drive();
    #1;
    model_step();
    if (data_valid && data_ready) tx_log.push_back(data);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i] && pend[i].size() > 0) void'(pend[i].pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_data", data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant", grant_id, 0);
    for (int i = 0; i < N; i++) begin
      pend[i].delete();
      gap[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_hdr  = 1'b0;
    m_ptr  = N - 1;
    @(negedge clk);
    arstn = 1'b1;
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (pend[i].size() > 0) return 1'b1;
    return m_busy;
  endfunction

  task automatic run_idle(input string tag, input int max);
    int n = 0;
    while (pending() && n < max) begin
      cycle();
      n++;
    end
    chk(tag, n < max, 1);
  endtask

  initial begin
    int start;
    int bytes;
    int pkts;
    int len;
    int r;
    logic [7:0] exp_q [$];

    req_valid = '1;
    data_ready = 1'b1;
    do_reset();

    // Single 3-byte packet from requester 2 with the transmitter always ready.
    pend[2] = '{9'h011, 9'h022, 9'h133};
    tx_log.delete();
    run_idle("single_timeout", 20);
    cycle();
    exp_q.delete();
    if (HDR) exp_q.push_back(8'h82);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    chk("single_len", tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) chk("single_byte", tx_log[i], exp_q[i]);

    // Round-robin order with every requester continuously holding 1-byte packets.
    do_reset();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < N; i++) pend[i].push_back(9'h100 | 9'(i * 16 + j));
    grant_log.delete();
    run_idle("rr_timeout", 60);
    chk("rr_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % N);

    // Transmitter stalls for 5 cycles right after arbitration.
    pend[1] = '{9'h0a5, 9'h15a};
    ready_lvl = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("stall_no_consume", pend[1].size(), 2);
    ready_lvl = 1'b1;
    run_idle("stall_timeout", 20);

    // Requester 1 pauses mid-packet while requester 3 keeps asking.
    do_reset();
    pend[1] = '{9'h001, 9'h002, 9'h003, 9'h104};
    pend[3] = '{9'h031, 9'h132};
    grant_log.delete();
    start = 0;
    while (pend[1].size() > 2 && start < 20) begin
      cycle();
      start++;
    end
    chk("gap_reach", start < 20, 1);
    gap[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("gap_grant_hold", grant_id, 1);
    end
    gap[1] = 1'b0;
    run_idle("gap_timeout", 40);
    chk("gap_order_n", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("gap_first", grant_log[0], 1);
      chk("gap_second", grant_log[1], 3);
    end

    // Reset lands while the second of four bytes is on the bus.
    do_reset();
    pend[0] = '{9'h0c1, 9'h0c2, 9'h0c3, 9'h1c4};
    start = 0;
    while (pend[0].size() > 3 && start < 20) begin
      cycle();
      start++;
    end
    chk("mid_reach", start < 20, 1);
    drive();
    #1;
    chk("mid_second_byte", data, 8'hc2);
    do_reset();
    pend[0] = '{9'h1e0};
    pend[2] = '{9'h1e2};
    grant_log.delete();
    run_idle("mid_timeout", 30);
    chk("mid_first_winner", grant_log.size() > 0 ? grant_log[0] : -1, 0);

    // Randomized traffic, gaps and backpressure against the model.
    do_reset();
    tx_log.delete();
    bytes = 0;
    pkts = 0;
    rnd_gap = 1'b1;
    rnd_ready = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(5) == 0) begin
        r = $urandom_range(N - 1);
        if (pend[r].size() < 8) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) pend[r].push_back({b == len - 1, 8'($urandom)});
          bytes += len;
          pkts++;
        end
      end
      cycle();
    end
    rnd_gap = 1'b0;
    rnd_ready = 1'b0;
    ready_lvl = 1'b1;
    run_idle("rand_drain", 400);
    chk("rand_bytes", tx_log.size(), bytes + (HDR ? pkts : 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
